// File: rtl/period_meter.sv
// period_meter
//   Measures the period and high time of in_sig, which is asynchronous to
//   clk, in clk cycles. One result is produced for each complete period,
//   counted from one rising edge to the next. Results are offered on a
//   valid/ready interface. Sticky flags report dropped results (overrun) and
//   counter saturation without a rising edge (timeout).
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   async active-low reset (assert async, release synchronised)
//   in_sig     in   measured signal, async to clk
//   clear      in   sync clear: drop the result and flags, return to WAIT
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result while out_valid is high
//   period     out  clk cycles between two consecutive rising edges
//   high_time  out  clk cycles from that rising edge to the falling edge
//   overrun    out  sticky: a result was dropped because of backpressure
//   timeout    out  sticky: counter saturated with no rising edge
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_WAIT | no reference rising edge yet; the next rise starts a measurement
// ST_HIGH | rise seen, waiting for fall (or a rise if the fall was missed)
// ST_LOW  | fall seen and latched in hi_q, waiting for the closing rise
module period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_sig,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   overrun,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  // Reset asserts immediately but releases on a clock edge so no flop sees
  // a release that races clk.
  logic rst_meta_n;
  logic rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_sig};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] hi_q, hi_d;
  logic                   valid_d;
  logic [COUNT_WIDTH-1:0] period_d;
  logic [COUNT_WIDTH-1:0] high_time_d;
  logic                   overrun_d;
  logic                   timeout_d;
  logic                   publish;
  logic [COUNT_WIDTH-1:0] pub_hi;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      hi_q      <= '0;
      out_valid <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      out_valid <= valid_d;
      period    <= period_d;
      high_time <= high_time_d;
      overrun   <= overrun_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    valid_d     = out_valid;
    period_d    = period;
    high_time_d = high_time;
    overrun_d   = overrun;
    timeout_d   = timeout;
    publish     = 1'b0;
    pub_hi      = hi_q;

    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_WAIT: begin
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (rise) begin
          // The fall was missed, so the whole period counts as high time.
          publish = 1'b1;
          pub_hi  = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT;
        end else if (fall) begin
          hi_d    = cnt_q;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          publish = 1'b1;
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (publish) begin
      timeout_d = 1'b0;
      if (out_valid && !out_ready) begin
        // Held result has priority; the new one is lost.
        overrun_d = 1'b1;
      end else begin
        valid_d     = 1'b1;
        period_d    = cnt_q;
        high_time_d = pub_hi;
      end
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      state_d   = ST_WAIT;
      cnt_d     = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_sig = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          overrun;
  logic          timeout;

  int total = 0;
  int bad = 0;
  int nxfer = 0;
  int armed = 0;
  int prev_h = 0;
  int prev_l = 0;
  int n0;

  typedef struct {
    int p;
    int h;
  } res_t;
  res_t expq[$];

  always #5 clk = ~clk;

  period_meter #(.SYNC_STAGES(2), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sig    (in_sig),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .period    (period),
    .high_time (high_time),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: drive inputs at the negedge, score a transfer that the
  // coming posedge will perform, then wait for the next negedge.
  task automatic cyc(input logic s, input logic rdy);
    res_t r;
    in_sig    = s;
    out_ready = rdy;
    if (out_valid === 1'b1 && rdy && !clear) begin
      nxfer++;
      chk("result_expected", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        r = expq.pop_front();
        chk("xfer_period", 32'(period), r.p);
        chk("xfer_high_time", 32'(high_time), r.h);
      end
    end
    @(negedge clk);
  endtask

  // One full in_sig period. The rise closes the previous period; keep says
  // whether the DUT is expected to accept that result.
  task automatic per(input int h, input int l, input logic rdy, input bit keep);
    if (armed != 0 && keep) expq.push_back('{prev_h + prev_l, prev_h});
    repeat (h) cyc(1'b1, rdy);
    repeat (l) cyc(1'b0, rdy);
    prev_h = h;
    prev_l = l;
    armed  = 1;
  endtask

  initial begin
    // reset
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_high_time", 32'(high_time), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b1);

    // 10/3 periods, ready high
    per(3, 7, 1'b1, 1'b1);
    chk("first_rise_silent", 32'(nxfer), 0);
    expq.push_back('{prev_h + prev_l, prev_h});
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("latency_edge2", 32'(out_valid), 0);
    cyc(1'b1, 1'b1);
    chk("latency_edge3", 32'(out_valid), 1);
    cyc(1'b0, 1'b1);
    chk("valid_single_pulse", 32'(out_valid), 0);
    repeat (6) cyc(1'b0, 1'b1);
    prev_h = 3;
    prev_l = 7;
    per(3, 7, 1'b1, 1'b1);
    per(3, 7, 1'b1, 1'b1);
    chk("t1_xfer_count", 32'(nxfer), 3);

    // backpressure: first result held, later ones dropped
    per(5, 7, 1'b0, 1'b1);
    chk("bp1_valid", 32'(out_valid), 1);
    chk("bp1_overrun", 32'(overrun), 0);
    per(5, 7, 1'b0, 1'b0);
    chk("bp2_valid", 32'(out_valid), 1);
    chk("bp2_period_stable", 32'(period), 10);
    chk("bp2_high_stable", 32'(high_time), 3);
    chk("bp2_overrun", 32'(overrun), 1);
    per(5, 7, 1'b0, 1'b0);
    chk("bp3_period_stable", 32'(period), 10);
    chk("bp3_valid", 32'(out_valid), 1);
    cyc(1'b0, 1'b1);
    prev_l = 8;
    chk("bp_drain_valid", 32'(out_valid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);

    // clear, then transfer and publish in the same cycle
    clear = 1'b1;
    cyc(1'b0, 1'b0);
    clear = 1'b0;
    expq.delete();
    armed = 0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_overrun", 32'(overrun), 0);
    chk("clr_keeps_period", 32'(period), 10);
    per(4, 6, 1'b0, 1'b1);
    per(3, 8, 1'b0, 1'b1);
    chk("hold_before_swap", 32'(period), 10);
    expq.push_back('{prev_h + prev_l, prev_h});
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("swap_valid", 32'(out_valid), 1);
    chk("swap_period", 32'(period), 11);
    chk("swap_high_time", 32'(high_time), 3);
    chk("swap_overrun", 32'(overrun), 0);
    repeat (6) cyc(1'b0, 1'b1);
    prev_h = 3;
    prev_l = 6;

    // timeout: rise then hold low until the counter saturates
    expq.push_back('{prev_h + prev_l, prev_h});
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (15) cyc(1'b0, 1'b1);
    chk("timeout_before_max", 32'(timeout), 0);
    cyc(1'b0, 1'b1);
    chk("timeout_at_max", 32'(timeout), 1);
    chk("timeout_no_valid", 32'(out_valid), 0);
    repeat (5) cyc(1'b0, 1'b1);
    armed = 0;
    n0 = nxfer;
    per(3, 5, 1'b1, 1'b1);
    chk("restart_silent", 32'(nxfer), n0);
    chk("restart_timeout_kept", 32'(timeout), 1);
    per(3, 5, 1'b1, 1'b1);
    chk("after_timeout_xfer", 32'(nxfer), n0 + 1);
    chk("after_timeout_cleared", 32'(timeout), 0);

    // reset mid-period
    expq.push_back('{prev_h + prev_l, prev_h});
    repeat (3) cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    chk("pre_reset_period", 32'(period), 8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_high_time", 32'(high_time), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b1);
    armed = 0;
    n0 = nxfer;
    per(4, 5, 1'b1, 1'b1);
    chk("post_rst_first_silent", 32'(nxfer), n0);
    per(4, 5, 1'b1, 1'b1);
    chk("post_rst_second_xfer", 32'(nxfer), n0 + 1);

    // clear against held result, overrun and a coinciding publish
    per(3, 6, 1'b0, 1'b1);
    per(3, 6, 1'b0, 1'b0);
    chk("pre_clr_overrun", 32'(overrun), 1);
    chk("pre_clr_valid", 32'(out_valid), 1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    clear = 1'b1;
    cyc(1'b1, 1'b0);
    clear = 1'b0;
    expq.delete();
    armed = 0;
    chk("clr2_valid", 32'(out_valid), 0);
    chk("clr2_overrun", 32'(overrun), 0);
    chk("clr2_timeout", 32'(timeout), 0);
    chk("clr2_period_kept", 32'(period), 9);
    chk("clr2_high_kept", 32'(high_time), 4);
    repeat (6) cyc(1'b0, 1'b1);
    n0 = nxfer;
    per(3, 6, 1'b1, 1'b1);
    chk("post_clr_silent", 32'(nxfer), n0);
    per(3, 6, 1'b1, 1'b1);
    chk("post_clr_xfer", 32'(nxfer), n0 + 1);

    // random periods within the 4-bit counter range
    n0 = nxfer;
    for (int i = 0; i < 40; i++) begin
      per(int'($urandom_range(1, 6)), int'($urandom_range(1, 7)), 1'b1, 1'b1);
    end
    per(3, 6, 1'b1, 1'b1);
    chk("rand_xfer_count", 32'(nxfer), n0 + 41);
    chk("rand_queue_empty", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
